// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the ID control word through ID/EX, EX/MEM, MEM/WB with load-use stall, branch flush, memory freeze and EX forwarding
//   in : clk, rst (sync, active-high), id_ctrl, id_rs1, id_rs2, id_rd, id_valid, ex_branch_taken, mem_busy
//   out: ex_ctrl/ex_rd, mem_ctrl/mem_rd, wb_ctrl/wb_rd (registered stages)
//        stall_if_id, flush_if_id, fwd_a, fwd_b (combinational)
module ctrl_pipe #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CTRL_WIDTH-1:0]     id_ctrl,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_valid,
  input  logic                      ex_branch_taken,
  input  logic                      mem_busy,
  output logic [CTRL_WIDTH-1:0]     ex_ctrl,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [CTRL_WIDTH-1:0]     mem_ctrl,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic [CTRL_WIDTH-1:0]     wb_ctrl,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      stall_if_id,
  output logic                      flush_if_id,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b
);
  localparam int REG_WRITE = 3;
  localparam int MEM_READ = 2;
  logic [CTRL_WIDTH-1:0] ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic load_use, bubble;
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
    if (mem_ctrl_q[REG_WRITE] && mem_rd_q != '0 && mem_rd_q == rs) return 2'b10;
    if (wb_ctrl_q[REG_WRITE] && wb_rd_q != '0 && wb_rd_q == rs) return 2'b01;
    return 2'b00;
  endfunction
  always_comb begin
    load_use = ex_ctrl_q[MEM_READ] & (ex_rd_q != '0) & id_valid & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
    bubble = ex_branch_taken | load_use | ~id_valid;
    // a taken branch kills the ID instruction, so it must not also stall
    stall_if_id = mem_busy | (load_use & ~ex_branch_taken);
    flush_if_id = ex_branch_taken & ~mem_busy;
    fwd_a = fwd_sel(ex_rs1_q);
    fwd_b = fwd_sel(ex_rs2_q);
  end
  always_comb begin
    ex_ctrl_d = mem_busy ? ex_ctrl_q : bubble ? '0 : id_ctrl;
    ex_rd_d = mem_busy ? ex_rd_q : bubble ? '0 : id_rd;
    ex_rs1_d = mem_busy ? ex_rs1_q : bubble ? '0 : id_rs1;
    ex_rs2_d = mem_busy ? ex_rs2_q : bubble ? '0 : id_rs2;
    mem_ctrl_d = mem_busy ? mem_ctrl_q : ex_ctrl_q;
    mem_rd_d = mem_busy ? mem_rd_q : ex_rd_q;
    // while memory is busy WB sees bubbles so the held instruction retires once
    wb_ctrl_d = mem_busy ? '0 : mem_ctrl_q;
    wb_rd_d = mem_busy ? '0 : mem_rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q <= '0;
      ex_rd_q <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      mem_ctrl_q <= '0;
      mem_rd_q <= '0;
      wb_ctrl_q <= '0;
      wb_rd_q <= '0;
    end else begin
      ex_ctrl_q <= ex_ctrl_d;
      ex_rd_q <= ex_rd_d;
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      mem_ctrl_q <= mem_ctrl_d;
      mem_rd_q <= mem_rd_d;
      wb_ctrl_q <= wb_ctrl_d;
      wb_rd_q <= wb_rd_d;
    end
  end
  assign ex_ctrl = ex_ctrl_q;
  assign ex_rd = ex_rd_q;
  assign mem_ctrl = mem_ctrl_q;
  assign mem_rd = mem_rd_q;
  assign wb_ctrl = wb_ctrl_q;
  assign wb_rd = wb_rd_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scoreboard bench for ctrl_pipe with directed scenarios and random traffic
module tb_ctrl_pipe;
  logic clk = 0, rst, id_valid, ex_branch_taken, mem_busy;
  logic [5:0] id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd;
  logic stall_if_id, flush_if_id;
  logic [1:0] fwd_a, fwd_b;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [5:0] c; logic [4:0] rd, rs1, rs2;} ins_t;
  typedef struct packed {
    logic [5:0] exc, memc, wbc;
    logic [4:0] exr, memr, wbr;
    logic st, fl;
    logic [1:0] fa, fb;
  } exp_t;
  ins_t p [1:3];
  exp_t q[$];
  ctrl_pipe dut (
    .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_valid(id_valid), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
    .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );
  always #5 clk = ~clk;
  function automatic logic [1:0] producer(input logic [4:0] rs);
    for (int s = 2; s <= 3; s++)
      if (p[s].c[3] && p[s].rd != 0 && p[s].rd == rs) return s == 2 ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic v, input logic br, input logic bz,
                     input logic [5:0] c, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    exp_t e;
    logic lu;
    @(negedge clk);
    rst = r; id_valid = v; ex_branch_taken = br; mem_busy = bz;
    id_ctrl = c; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    lu = p[1].c[2] && p[1].rd != 0 && v && (p[1].rd == rs1 || p[1].rd == rs2);
    e.exc = p[1].c; e.exr = p[1].rd;
    e.memc = p[2].c; e.memr = p[2].rd;
    e.wbc = p[3].c; e.wbr = p[3].rd;
    e.st = bz | (lu & !br);
    e.fl = br & !bz;
    e.fa = producer(p[1].rs1);
    e.fb = producer(p[1].rs2);
    q.push_back(e);
    if (r) for (int s = 1; s <= 3; s++) p[s] = '0;
    else if (bz) p[3] = '0;
    else begin
      p[3] = p[2];
      p[2] = p[1];
      p[1] = (br || lu || !v) ? '0 : {c, rd, rs1, rs2};
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ex_ctrl", {2'b0, ex_ctrl}, {2'b0, e.exc});
      chk("ex_rd", {3'b0, ex_rd}, {3'b0, e.exr});
      chk("mem_ctrl", {2'b0, mem_ctrl}, {2'b0, e.memc});
      chk("mem_rd", {3'b0, mem_rd}, {3'b0, e.memr});
      chk("wb_ctrl", {2'b0, wb_ctrl}, {2'b0, e.wbc});
      chk("wb_rd", {3'b0, wb_rd}, {3'b0, e.wbr});
      chk("stall_if_id", {7'b0, stall_if_id}, {7'b0, e.st});
      chk("flush_if_id", {7'b0, flush_if_id}, {7'b0, e.fl});
      chk("fwd_a", {6'b0, fwd_a}, {6'b0, e.fa});
      chk("fwd_b", {6'b0, fwd_b}, {6'b0, e.fb});
    end
  end
  initial begin
    rst = 1; id_valid = 0; ex_branch_taken = 0; mem_busy = 0;
    id_ctrl = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    for (int s = 1; s <= 3; s++) p[s] = '0;
    repeat (2) @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 6'b101000, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b111100, 5, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 6'b001000, 6, 5, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b001000, 3, 1, 2);
    cyc(0, 1, 0, 0, 6'b001000, 3, 4, 4);
    cyc(0, 1, 0, 0, 6'b001000, 7, 1, 3);
    cyc(0, 1, 0, 0, 6'b001000, 0, 1, 2);
    cyc(0, 1, 0, 0, 6'b001000, 8, 2, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b111100, 2, 0, 0);
    cyc(0, 1, 1, 0, 6'b001000, 4, 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b100010, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 1, 6'b101000, 9, 0, 0);
    repeat (4) cyc(0, 1, 0, 0, 6'b101000, 9, 0, 0);
    cyc(0, 1, 0, 0, 6'b111100, 7, 0, 0);
    cyc(0, 1, 0, 0, 6'b001000, 6, 7, 0);
    cyc(1, 1, 0, 0, 6'b001000, 6, 7, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 15, 6'($urandom), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    @(negedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
